// File: rtl/xadc_capture_pkg.sv
// Shared types and constants for the XADC DRP capture block.
// Timestamp width is a module parameter, so the full FIFO entry is assembled in the top.
package xadc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    PUSH = 2'd3
  } xadc_state_e;

  localparam int DRP_ADDR_W      = 7;
  localparam int XADC_SAMPLE_LSB = 4;
  localparam int CHAN_W          = 5;
  localparam int SAMPLE_W        = 12;

  typedef struct packed {
    logic [CHAN_W-1:0]   channel;
    logic [SAMPLE_W-1:0] sample;
  } sample_tag_t;

  function automatic logic [DRP_ADDR_W-1:0] drp_addr(input logic [CHAN_W-1:0] ch);
    return {2'b00, ch};
  endfunction

endpackage

// File: rtl/xadc_drp_capture_if.sv
// DRP master port plus the FIFO read port toward the AXI-Lite register stage.
// Handshakes: den_out is a one-cycle request answered by one drdy_in pulse carrying do_in;
// a pop happens on any cycle where rd_valid & rd_en, and rd_* always shows the head while rd_valid.
interface xadc_drp_capture_if #(
    parameter int TS_WIDTH = 32
) ();
  logic                den_out;
  logic                dwe_out;
  logic [6:0]          daddr_out;
  logic                drdy_in;
  logic [15:0]         do_in;
  logic                rd_en;
  logic                rd_valid;
  logic [4:0]          rd_channel;
  logic [11:0]         rd_sample;
  logic [TS_WIDTH-1:0] rd_timestamp;

  modport master (
    output den_out, dwe_out, daddr_out,
    input  drdy_in, do_in,
    input  rd_en,
    output rd_valid, rd_channel, rd_sample, rd_timestamp
  );

  modport slave (
    input  den_out, dwe_out, daddr_out,
    output drdy_in, do_in,
    output rd_en,
    input  rd_valid, rd_channel, rd_sample, rd_timestamp
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock show-ahead FIFO; head data reads as zero while empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_pop;
    logic             do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/xadc_drp_capture.sv
// Captures XADC conversions over DRP, tags them with a free-running timestamp
// and queues {channel, sample, timestamp} for the AXI-Lite register stage.
module xadc_drp_capture
  import xadc_capture_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int TS_WIDTH     = 32,
    parameter int DRDY_TIMEOUT = 15,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic                         enable,
    input  logic [31:0]                  chan_mask,
    input  logic                         eoc_in,
    input  logic [CHAN_W-1:0]            channel_in,
    xadc_drp_capture_if.master           bus,
    input  logic                         clr_status,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    output logic [CNT_WIDTH-1:0]         missed_cnt,
    output logic [CNT_WIDTH-1:0]         timeout_cnt,
    output logic [1:0]                   state_dbg
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_PUSH = PUSH;
    localparam int WCNT_W = $clog2(DRDY_TIMEOUT + 1);

    typedef struct packed {
        sample_tag_t         tag;
        logic [TS_WIDTH-1:0] timestamp;
    } sample_entry_t;

    logic [1:0]            state;
    logic [TS_WIDTH-1:0]   ts;
    logic [TS_WIDTH-1:0]   ts_lat;
    logic [CHAN_W-1:0]     chan_lat;
    logic [SAMPLE_W-1:0]   sample_lat;
    logic [DRP_ADDR_W-1:0] daddr_q;
    logic [WCNT_W-1:0]     wait_cnt;

    logic qualified;
    logic accept;
    logic missed_ev;
    logic timeout_ev;
    logic push_req;
    logic drop_ev;
    logic fifo_full;
    logic fifo_empty;

    sample_entry_t wr_entry;
    sample_entry_t head;

    function automatic logic [CNT_WIDTH-1:0] sat_next(input logic [CNT_WIDTH-1:0] cur,
                                                       input logic ev, input logic clr);
        if (ev) begin
            return clr ? CNT_WIDTH'(1) : ((&cur) ? cur : cur + CNT_WIDTH'(1));
        end
        return clr ? '0 : cur;
    endfunction

    assign qualified  = eoc_in && enable && chan_mask[channel_in];
    assign accept     = qualified && (state == ST_IDLE);
    assign missed_ev  = qualified && (state != ST_IDLE);
    assign timeout_ev = (state == ST_WAIT) && !bus.drdy_in && (wait_cnt == WCNT_W'(DRDY_TIMEOUT));
    assign push_req   = (state == ST_PUSH);
    // Full with a same-cycle pop still takes the entry, so only a full, idle reader drops it.
    assign drop_ev    = push_req && fifo_full && !bus.rd_en;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= ST_IDLE;
            ts         <= '0;
            ts_lat     <= '0;
            chan_lat   <= '0;
            sample_lat <= '0;
            daddr_q    <= '0;
            wait_cnt   <= '0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        chan_lat <= channel_in;
                        ts_lat   <= ts;
                        daddr_q  <= drp_addr(channel_in);
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    wait_cnt <= WCNT_W'(1);
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.drdy_in) begin
                        sample_lat <= bus.do_in[15:XADC_SAMPLE_LSB];
                        state      <= ST_PUSH;
                    end else if (timeout_ev) begin
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                ST_PUSH: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            overflow    <= 1'b0;
            missed_cnt  <= '0;
            timeout_cnt <= '0;
        end else begin
            overflow    <= drop_ev || (overflow && !clr_status);
            missed_cnt  <= sat_next(missed_cnt, missed_ev, clr_status);
            timeout_cnt <= sat_next(timeout_cnt, timeout_ev, clr_status);
        end
    end

    assign wr_entry.tag.channel = chan_lat;
    assign wr_entry.tag.sample  = sample_lat;
    assign wr_entry.timestamp   = ts_lat;

    sync_fifo_fwft #(
        .WIDTH ($bits(sample_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .push  (push_req),
        .wdata (wr_entry),
        .pop   (bus.rd_en),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.den_out      = (state == ST_REQ);
    assign bus.dwe_out      = 1'b0;
    assign bus.daddr_out    = daddr_q;
    assign bus.rd_valid     = !fifo_empty;
    assign bus.rd_channel   = head.tag.channel;
    assign bus.rd_sample    = head.tag.sample;
    assign bus.rd_timestamp = head.timestamp;
    assign state_dbg        = state;
endmodule
